// File: rtl/wts_tone_generator_nch_pkg.sv
// Shared definitions for the time-multiplexed tone generator: wave-length codes,
// legal channel-count bounds and the wave-size helper.
package wts_pkg;

  typedef enum logic [1:0] {
    WLEN_BASE = 2'd0,
    WLEN_X2   = 2'd1,
    WLEN_X4   = 2'd2,
    WLEN_X8   = 2'd3
  } wave_len_e;

  localparam int CH_NUM_MIN = 1;
  localparam int CH_NUM_MAX = 8;
  localparam int ADDR_W_MIN = 4;

  // log2 of the wave size in samples for a given address width and length code
  function automatic int wave_shift(input int addr_w, input wave_len_e len);
    return addr_w - 3 + int'(len);
  endfunction

endpackage

// File: rtl/wts_tone_generator_nch_if.sv
// Per-slot control bundle for the tone generator: the register values presented
// for the channel serviced in the current cycle.
interface wts_tone_generator_nch_if
  import wts_pkg::*;
#(
  parameter int FREQ_W = 12
) ();

  logic              address_reset;
  logic              enable;
  logic              one_shot;
  wave_len_e         wave_length;
  logic [FREQ_W-1:0] frequency_count;

  modport master (
    output address_reset, enable, one_shot, wave_length, frequency_count
  );

  modport slave (
    input address_reset, enable, one_shot, wave_length, frequency_count
  );

endinterface

// File: rtl/wts_tone_generator_nch_step.sv
// Combinational next-state for one channel slot; a single instance is shared by
// every channel through the slot multiplexer in the top level.
module wts_tone_step
  import wts_pkg::*;
#(
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
) (
  wts_tone_generator_nch_if.slave ctrl,
  input  logic [ADDR_W-1:0] cur_address,
  input  logic [FREQ_W-1:0] cur_count,
  input  logic              cur_done,
  output logic [ADDR_W-1:0] nxt_address,
  output logic [FREQ_W-1:0] nxt_count,
  output logic              nxt_done,
  output logic              half_timing
);

  logic [ADDR_W:0]   size;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] inc;

  assign size = (ADDR_W+1)'(1) << wave_shift(ADDR_W, ctrl.wave_length);
  assign mask = ADDR_W'(size - 1'b1);
  // Masking on the step (not on the stored value) lets a shrunk length resume from masked+1
  assign inc  = (cur_address + 1'b1) & mask;

  always_comb begin
    nxt_address = cur_address;
    nxt_count   = cur_count;
    nxt_done    = cur_done;
    if (ctrl.address_reset) begin
      nxt_address = '0;
      nxt_count   = ctrl.frequency_count;
      nxt_done    = 1'b0;
    end else if (ctrl.enable && !cur_done) begin
      if (cur_count != '0) begin
        nxt_count = cur_count - 1'b1;
      end else begin
        nxt_count = ctrl.frequency_count;
        if (ctrl.one_shot && (cur_address == mask)) begin
          nxt_done = 1'b1;
        end else begin
          nxt_address = inc;
        end
      end
    end
  end

  assign half_timing = ctrl.enable && !cur_done &&
                       (cur_count == (ctrl.frequency_count >> 1));

endmodule

// File: rtl/wts_tone_generator_nch.sv
// Time-multiplexed N-channel wave-table tone address generator: one channel is
// serviced per cycle, selected by `active`, with state held in per-channel arrays.
module wts_tone_generator_nch
  import wts_pkg::*;
#(
  parameter int  CH_NUM = 5,
  parameter int  FREQ_W = 12,
  parameter int  ADDR_W = 7,
  localparam int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              nreset,
  input  logic              clk,
  input  logic [SEL_W-1:0]  active,
  input  logic              address_reset,
  input  logic              reg_enable,
  input  logic              reg_one_shot,
  input  logic [1:0]        reg_wave_length,
  input  logic [FREQ_W-1:0] reg_frequency_count,
  output logic [ADDR_W-1:0] wave_address,
  output logic              half_timing,
  output logic              wave_end
);

  logic [ADDR_W-1:0] address_q [CH_NUM];
  logic [FREQ_W-1:0] count_q   [CH_NUM];
  logic              done_q    [CH_NUM];

  logic              valid;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] nxt_address;
  logic [FREQ_W-1:0] nxt_count;
  logic              nxt_done;
  logic              step_half;

  // Out-of-range slots are idle: outputs forced low, array index parked on 0
  assign valid = (int'(active) < CH_NUM);
  assign sel   = valid ? active : '0;

  wts_tone_generator_nch_if #(.FREQ_W(FREQ_W)) ctrl ();

  assign ctrl.address_reset   = address_reset;
  assign ctrl.enable          = reg_enable;
  assign ctrl.one_shot        = reg_one_shot;
  assign ctrl.wave_length     = wave_len_e'(reg_wave_length);
  assign ctrl.frequency_count = reg_frequency_count;

  wts_tone_step #(
    .FREQ_W (FREQ_W),
    .ADDR_W (ADDR_W)
  ) u_step (
    .ctrl        (ctrl),
    .cur_address (address_q[sel]),
    .cur_count   (count_q[sel]),
    .cur_done    (done_q[sel]),
    .nxt_address (nxt_address),
    .nxt_count   (nxt_count),
    .nxt_done    (nxt_done),
    .half_timing (step_half)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        address_q[i] <= '0;
        count_q[i]   <= '0;
        done_q[i]    <= 1'b0;
      end
    end else if (valid) begin
      address_q[sel] <= nxt_address;
      count_q[sel]   <= nxt_count;
      done_q[sel]    <= nxt_done;
    end
  end

  // Reset gates the outputs too, since a cleared channel with freq 0 would otherwise strobe
  assign wave_address = (nreset && valid) ? address_q[sel] : '0;
  assign wave_end     = nreset && valid && done_q[sel];
  assign half_timing  = nreset && valid && step_half;

endmodule

// File: tb/tb_wts_tone_generator_nch.sv
// Directed bench for the tone generator: three instances (5ch/7b, 1ch/7b, 8ch/8b)
// driven by a linear sequence of services with hand-computed expectations.
module tb_wts_tone_generator_nch;
  import wts_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  wts_tone_generator_nch_if #(.FREQ_W(12)) bus5 ();
  wts_tone_generator_nch_if #(.FREQ_W(12)) bus1 ();
  wts_tone_generator_nch_if #(.FREQ_W(12)) bus8 ();

  logic [2:0] act5;
  logic       act1;
  logic [2:0] act8;
  logic [6:0] wa5;
  logic       he5, we5;
  logic [6:0] wa1;
  logic       he1, we1;
  logic [7:0] wa8;
  logic       he8, we8;

  wts_tone_generator_nch #(.CH_NUM(5), .FREQ_W(12), .ADDR_W(7)) u_dut5 (
    .nreset(nreset), .clk(clk), .active(act5),
    .address_reset(bus5.address_reset), .reg_enable(bus5.enable),
    .reg_one_shot(bus5.one_shot), .reg_wave_length(bus5.wave_length),
    .reg_frequency_count(bus5.frequency_count),
    .wave_address(wa5), .half_timing(he5), .wave_end(we5));

  wts_tone_generator_nch #(.CH_NUM(1), .FREQ_W(12), .ADDR_W(7)) u_dut1 (
    .nreset(nreset), .clk(clk), .active(act1),
    .address_reset(bus1.address_reset), .reg_enable(bus1.enable),
    .reg_one_shot(bus1.one_shot), .reg_wave_length(bus1.wave_length),
    .reg_frequency_count(bus1.frequency_count),
    .wave_address(wa1), .half_timing(he1), .wave_end(we1));

  wts_tone_generator_nch #(.CH_NUM(8), .FREQ_W(12), .ADDR_W(8)) u_dut8 (
    .nreset(nreset), .clk(clk), .active(act8),
    .address_reset(bus8.address_reset), .reg_enable(bus8.enable),
    .reg_one_shot(bus8.one_shot), .reg_wave_length(bus8.wave_length),
    .reg_frequency_count(bus8.frequency_count),
    .wave_address(wa8), .half_timing(he8), .wave_end(we8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set5(input int ch, input logic rst, input logic en, input logic os,
                      input int len, input int freq);
    act5 = 3'(ch);
    bus5.address_reset = rst;
    bus5.enable = en;
    bus5.one_shot = os;
    bus5.wave_length = wave_len_e'(2'(len));
    bus5.frequency_count = 12'(freq);
  endtask

  task automatic set1(input int ch, input logic rst, input logic en, input logic os,
                      input int len, input int freq);
    act1 = 1'(ch);
    bus1.address_reset = rst;
    bus1.enable = en;
    bus1.one_shot = os;
    bus1.wave_length = wave_len_e'(2'(len));
    bus1.frequency_count = 12'(freq);
  endtask

  task automatic set8(input int ch, input logic rst, input logic en, input logic os,
                      input int len, input int freq);
    act8 = 3'(ch);
    bus8.address_reset = rst;
    bus8.enable = en;
    bus8.one_shot = os;
    bus8.wave_length = wave_len_e'(2'(len));
    bus8.frequency_count = 12'(freq);
  endtask

  task automatic svc5(input int ch, input logic rst, input logic en, input logic os,
                      input int len, input int freq);
    set5(ch, rst, en, os, len, freq);
    @(posedge clk);
    #1;
  endtask

  task automatic svc1(input int ch, input logic rst, input logic en, input logic os,
                      input int len, input int freq);
    set1(ch, rst, en, os, len, freq);
    @(posedge clk);
    #1;
  endtask

  task automatic svc8(input int ch, input logic rst, input logic en, input logic os,
                      input int len, input int freq);
    set8(ch, rst, en, os, len, freq);
    @(posedge clk);
    #1;
  endtask

  task automatic peek5(input int ch, input logic en, input int freq);
    set5(ch, 1'b0, en, 1'b0, 0, freq);
    #1;
  endtask

  initial begin
    int hcount;
    set5(0, 1'b0, 1'b1, 1'b0, 0, 0);
    set1(0, 1'b0, 1'b1, 1'b0, 0, 0);
    set8(0, 1'b0, 1'b1, 1'b0, 0, 0);
    nreset = 1'b0;
    #2;
    // Reset state: enabled with freq 0 would strobe half_timing if not gated
    for (int ch = 0; ch < 5; ch++) begin
      act5 = 3'(ch);
      #1;
      check("rst5_addr", 32'(wa5), 32'd0);
      check("rst5_half", 32'(he5), 32'd0);
      check("rst5_end", 32'(we5), 32'd0);
    end
    check("rst1_half", 32'(he1), 32'd0);
    check("rst8_half", 32'(he8), 32'd0);
    set5(0, 1'b0, 1'b0, 1'b0, 0, 0);
    set1(0, 1'b0, 1'b0, 1'b0, 0, 0);
    set8(0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Loop stepping on ch2, freq 3, round-robin service
    svc5(2, 1'b1, 1'b1, 1'b0, 0, 3);
    peek5(2, 1'b1, 3);
    check("loop_start", 32'(wa5), 32'd0);
    for (int r = 1; r <= 68; r++) begin
      for (int ch = 0; ch < 5; ch++) svc5(ch, 1'b0, (ch == 2), 1'b0, 0, 3);
      peek5(2, 1'b1, 3);
      check("loop_addr", 32'(wa5), 32'((r / 4) % 16));
      check("loop_half", 32'(he5), 32'((r % 4) == 2));
    end

    // One-shot on ch0, freq 0
    svc5(0, 1'b1, 1'b1, 1'b1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      svc5(0, 1'b0, 1'b1, 1'b1, 0, 0);
      peek5(0, 1'b1, 0);
      check("os_addr", 32'(wa5), 32'((k < 15) ? k : 15));
      check("os_end", 32'(we5), 32'(k >= 16));
    end
    svc5(0, 1'b0, 1'b1, 1'b0, 0, 0);
    peek5(0, 1'b1, 0);
    check("os_loopmode_addr", 32'(wa5), 32'd15);
    check("os_loopmode_end", 32'(we5), 32'd1);
    svc5(0, 1'b1, 1'b1, 1'b1, 0, 0);
    peek5(0, 1'b1, 0);
    check("os_restart_addr", 32'(wa5), 32'd0);
    check("os_restart_end", 32'(we5), 32'd0);

    // Isolation: ch3 parked at addr 1 / count 1, ch1 running, out-of-range slots
    svc5(3, 1'b1, 1'b1, 1'b0, 1, 2);
    for (int k = 0; k < 4; k++) svc5(3, 1'b0, 1'b1, 1'b0, 1, 2);
    svc5(1, 1'b1, 1'b1, 1'b0, 0, 1);
    for (int i = 0; i < 50; i++) begin
      svc5(1, 1'b0, 1'b1, 1'b0, 0, 1);
      svc5(3, 1'b0, 1'b0, 1'b0, 1, 5);
    end
    for (int ch = 5; ch < 8; ch++) begin
      set5(ch, 1'b1, 1'b1, 1'b0, 0, 0);
      #1;
      check("oor_addr", 32'(wa5), 32'd0);
      check("oor_half", 32'(he5), 32'd0);
      check("oor_end", 32'(we5), 32'd0);
      bus5.frequency_count = 12'd7;
      @(posedge clk);
      #1;
    end
    peek5(3, 1'b1, 2);
    check("iso3_addr", 32'(wa5), 32'd1);
    check("iso3_half", 32'(he5), 32'd1);
    peek5(1, 1'b1, 1);
    check("iso1_addr", 32'(wa5), 32'd9);
    peek5(0, 1'b1, 0);
    check("iso0_addr", 32'(wa5), 32'd0);
    check("iso0_half", 32'(he5), 32'd1);

    // half_timing strobe with freq 6 on ch4
    svc5(4, 1'b1, 1'b1, 1'b0, 0, 6);
    hcount = 0;
    for (int k = 1; k <= 21; k++) begin
      svc5(4, 1'b0, 1'b1, 1'b0, 0, 6);
      peek5(4, 1'b1, 6);
      check("half_strobe", 32'(he5), 32'((k % 7) == 3));
      if (he5) hcount++;
    end
    check("half_count", 32'(hcount), 32'd3);
    check("half_addr", 32'(wa5), 32'd3);

    // Async reset with ch4 mid-sequence at address 9
    svc5(4, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 9; k++) svc5(4, 1'b0, 1'b1, 1'b0, 0, 0);
    peek5(4, 1'b1, 0);
    check("ar_pre_addr", 32'(wa5), 32'd9);
    nreset = 1'b0;
    #1;
    check("ar_addr", 32'(wa5), 32'd0);
    check("ar_half", 32'(he5), 32'd0);
    check("ar_end", 32'(we5), 32'd0);
    act5 = 3'd2;
    #1;
    check("ar_ch2_addr", 32'(wa5), 32'd0);
    set5(0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    peek5(4, 1'b1, 0);
    check("ar_post4_addr", 32'(wa5), 32'd0);
    peek5(2, 1'b1, 3);
    check("ar_post2_addr", 32'(wa5), 32'd0);
    svc5(4, 1'b0, 1'b1, 1'b0, 0, 0);
    peek5(4, 1'b1, 0);
    check("ar_restart_addr", 32'(wa5), 32'd1);

    // Length shrink 3 -> 0 at address 100
    svc5(4, 1'b1, 1'b1, 1'b0, 3, 0);
    for (int k = 0; k < 100; k++) svc5(4, 1'b0, 1'b1, 1'b0, 3, 0);
    peek5(4, 1'b1, 0);
    check("shrink_pre", 32'(wa5), 32'd100);
    svc5(4, 1'b0, 1'b1, 1'b0, 0, 0);
    peek5(4, 1'b1, 0);
    check("shrink_step1", 32'(wa5), 32'd5);
    svc5(4, 1'b0, 1'b1, 1'b0, 0, 0);
    peek5(4, 1'b1, 0);
    check("shrink_step2", 32'(wa5), 32'd6);

    // CH_NUM=1 instance
    svc1(0, 1'b1, 1'b1, 1'b0, 0, 1);
    for (int k = 1; k <= 34; k++) begin
      svc1(0, 1'b0, 1'b1, 1'b0, 0, 1);
      set1(0, 1'b0, 1'b1, 1'b0, 0, 1);
      #1;
      check("c1_addr", 32'(wa1), 32'((k / 2) % 16));
    end
    set1(1, 1'b1, 1'b1, 1'b0, 0, 0);
    #1;
    check("c1_oor_addr", 32'(wa1), 32'd0);
    check("c1_oor_half", 32'(he1), 32'd0);
    @(posedge clk);
    #1;
    set1(0, 1'b0, 1'b1, 1'b0, 0, 1);
    #1;
    check("c1_hold_addr", 32'(wa1), 32'd1);
    check("c1_hold_end", 32'(we1), 32'd0);

    // CH_NUM=8, ADDR_W=8 instance: one-shot size 32 on ch7, shrink on ch5
    svc8(7, 1'b1, 1'b1, 1'b1, 0, 0);
    for (int k = 1; k <= 33; k++) begin
      svc8(7, 1'b0, 1'b1, 1'b1, 0, 0);
      check("c8_os_addr", 32'(wa8), 32'((k < 31) ? k : 31));
      check("c8_os_end", 32'(we8), 32'(k >= 32));
    end
    svc8(5, 1'b1, 1'b1, 1'b0, 3, 0);
    for (int k = 0; k < 200; k++) svc8(5, 1'b0, 1'b1, 1'b0, 3, 0);
    check("c8_shrink_pre", 32'(wa8), 32'd200);
    svc8(5, 1'b0, 1'b1, 1'b0, 1, 0);
    check("c8_shrink_step", 32'(wa8), 32'd9);
    set8(7, 1'b0, 1'b0, 1'b1, 0, 0);
    #1;
    check("c8_iso7_addr", 32'(wa8), 32'd31);
    check("c8_iso7_end", 32'(we8), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wts_tone_generator_nch.md
WTS_TONE_GENERATOR_NCH -- requirements
Module: wts_tone_generator_nch

Interface
REQ-001 SHALL have parameter CH_NUM, default 5, number of time-multiplexed channels, legal range 1..8.
REQ-002 SHALL have parameter FREQ_W, default 12, frequency counter width.
REQ-003 SHALL have parameter ADDR_W, default 7, wave address width, minimum 4.
REQ-004 SHALL have derived localparam SEL_W, equal to max(1, clog2(CH_NUM)), the slot index width.
REQ-005 SHALL have port nreset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port clk, input, 1 bit, clock.
REQ-007 SHALL have port active, input, SEL_W bits, index of the channel serviced this cycle.
REQ-008 SHALL have port address_reset, input, 1 bit, restarts the active channel.
REQ-009 SHALL have port reg_enable, input, 1 bit, active channel run enable.
REQ-010 SHALL have port reg_one_shot, input, 1 bit, active channel mode: 0 loop, 1 one-shot.
REQ-011 SHALL have port reg_wave_length, input, 2 bits, active channel wave length code.
REQ-012 SHALL have port reg_frequency_count, input, FREQ_W bits, active channel reload value.
REQ-013 SHALL have port wave_address, output, ADDR_W bits, stored address of the active channel.
REQ-014 SHALL have port half_timing, output, 1 bit, midpoint strobe for the active channel.
REQ-015 SHALL have port wave_end, output, 1 bit, one-shot-finished flag of the active channel.

Function
REQ-016 SHALL hold one address register (ADDR_W bits), one count register (FREQ_W bits) and one done flag per channel.
REQ-017 SHALL drive wave_address, wave_end and half_timing combinationally from the stored state of channel `active`; no pipeline stage on the outputs.
REQ-018 SHALL, when active >= CH_NUM, drive all outputs to 0 and update no state.
REQ-019 SHALL, at each rising clk edge, update only channel `active`, in the following priority order.
REQ-020 SHALL, when address_reset=1, set address=0, count=reg_frequency_count and done=0, regardless of reg_enable.
REQ-021 SHALL, when reg_enable=0 or done=1, hold the channel state.
REQ-022 SHALL, when count != 0, decrement count by 1.
REQ-023 SHALL, when count == 0, reload count=reg_frequency_count and step the address.
REQ-024 SHALL define wave size as 2^(ADDR_W-3+reg_wave_length) for codes 0..3; with ADDR_W=7 this gives 16, 32, 64 and 128 samples.
REQ-025 SHALL, on a step, set address=(address+1) AND (size-1); upper address bits are forced to 0.
REQ-026 SHALL, on a step in one-shot mode when address == size-1, hold address at size-1 and set done=1 instead of wrapping.
REQ-027 SHALL assert half_timing when channel enabled, done=0 and stored count == reg_frequency_count>>1 (unsigned shift).
REQ-028 SHALL give a period of (reg_frequency_count+1) serviced slots per address step; reg_frequency_count=0 steps on every service.
REQ-029 SHALL, if reg_wave_length shrinks while the address exceeds the new size-1, apply the mask at the next step, so the sequence continues from the masked value +1.
REQ-030 SHALL, when reg_one_shot is changed 1->0 while done=1, keep the channel stalled until address_reset.

Reset
REQ-031 SHALL, on nreset=0, asynchronously clear every address, count and done register to 0.
REQ-032 SHALL, while nreset=0, drive outputs to 0 (wave_address=0, wave_end=0, half_timing=0) for every `active` value.
REQ-033 SHALL abandon a mid-sequence channel immediately on reset, with no completion.

Structure
REQ-034 SHALL place the wave-length code encodings and the CH_NUM legal bounds in shared package wts_pkg.
REQ-035 SHALL implement the per-channel next-state logic as combinational sub-module wts_tone_step, instantiated once and shared across slots.
REQ-036 SHALL implement the channel state as arrays indexed by `active`; no per-channel hand copies.
REQ-037 SHALL scale to 120-400 RTL lines; synthesis SHALL report no latches.

Verification
REQ-038 SHALL cover loop stepping: CH_NUM=5, ch2, freq=3, len=0, enable, round-robin active 0..4 -> ch2 address advances every 4 services, 15 -> 0 wrap.
REQ-039 SHALL cover one-shot: ch0, freq=0, len=0, one_shot=1 -> address 0..15 then holds at 15 with wave_end=1; address_reset -> address 0, wave_end 0.
REQ-040 SHALL cover channel isolation: ch1 enabled freq=1, ch3 disabled -> ch3 address/count unchanged across 100 cycles; active=5,6,7 -> outputs 0 and no state change.
REQ-041 SHALL cover the half_timing strobe: freq=6 -> half_timing high exactly when count==3, once per step period.
REQ-042 SHALL cover async reset: nreset pulse mid-sequence with ch4 at address 9 -> all outputs 0 immediately, ch4 restarts from 0 after release.
REQ-043 SHALL cover length shrink and parameter sweep: len 3->0 at address 100 -> next address 5; the bench SHALL repeat with CH_NUM=1 and CH_NUM=8, ADDR_W=8.
